// File: rtl/module_bcd_to_bin_pkg.sv
// ----------------------------------------------------------------------------
// pkg_bcd
// Shared types and constants for the BCD-to-signed-binary converter.
//   bcd2bin_state_t : converter FSM state encoding
//   BCD_FIX_THR/SUB : reverse double-dabble digit correction (>= 8 -> -3)
//   is_bcd()        : 1 when a nibble is a legal decimal digit (0..9)
// ----------------------------------------------------------------------------
package pkg_bcd;

  typedef enum logic [1:0] {IDLE, CONV, SIGN, DONE} bcd2bin_state_t;

  localparam logic [3:0] BCD_FIX_THR = 4'd8;
  localparam logic [3:0] BCD_FIX_SUB = 4'd3;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return (nibble <= 4'd9);
  endfunction

endpackage

// File: rtl/module_bcd_to_bin_if.sv
// ----------------------------------------------------------------------------
// module_bcd_to_bin_if
// Request/result bundle between the keypad entry stage (master) and the
// BCD-to-binary converter (slave).
//   valid_in   : one-cycle request strobe
//   neg_in     : 1 = negative value
//   bcd_in     : packed BCD, [3:0] = units
//   numero_out : signed result, held until the next completion
//   listo      : one-cycle completion pulse
//   busy       : converter not idle
//   error      : last request contained a non-decimal nibble
//   ovf        : last result was saturated
// ----------------------------------------------------------------------------
interface module_bcd_to_bin_if #(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 8
);

  logic                  valid_in;
  logic                  neg_in;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [WIDTH-1:0]      numero_out;
  logic                  listo;
  logic                  busy;
  logic                  error;
  logic                  ovf;

  modport master (
    output valid_in, neg_in, bcd_in,
    input  numero_out, listo, busy, error, ovf
  );

  modport slave (
    input  valid_in, neg_in, bcd_in,
    output numero_out, listo, busy, error, ovf
  );

endinterface

// File: rtl/module_bcd_to_bin_nibble_fix.sv
// ----------------------------------------------------------------------------
// module_bcd_nibble_fix
// Combinational correction for one BCD digit after a right shift in the
// reverse double-dabble: a digit that reads >= 8 had a "ten" shifted into
// its MSB, which is worth 5 rather than 8, so 3 is subtracted.
//   nib_in  : post-shift digit
//   nib_out : corrected digit
// ----------------------------------------------------------------------------
module module_bcd_nibble_fix
  import pkg_bcd::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  assign nib_out = (nib_in >= BCD_FIX_THR) ? (nib_in - BCD_FIX_SUB) : nib_in;

endmodule

// File: rtl/module_bcd_to_bin.sv
// ----------------------------------------------------------------------------
// module_bcd_to_bin
// Sequential BCD-to-signed-binary converter feeding the Booth multiplier.
// Reverse double-dabble, one bit per cycle, then sign application with
// saturation to the WIDTH-bit two's-complement range.
//   clk_div : divided system clock
//   rst     : asynchronous active-high reset (released synchronously)
//   bus     : request/result bundle, slave side
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for valid_in; latches request and validates digits
// CONV  | one right shift + digit correction per cycle, 4*DIGITS cycles
// SIGN  | saturate / negate magnitude, register result
// DONE  | listo pulse, back to IDLE
// ----------------------------------------------------------------------------
module module_bcd_to_bin
  import pkg_bcd::*;
#(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 8
) (
  input  logic                      clk_div,
  input  logic                      rst,
  module_bcd_to_bin_if.slave        bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BCD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCD_W - 1);

  localparam int unsigned POS_LIM = (2 ** (WIDTH - 1)) - 1;
  localparam int unsigned NEG_LIM = 2 ** (WIDTH - 1);
  localparam logic [WIDTH-1:0] POS_SAT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_SAT = {1'b1, {(WIDTH-1){1'b0}}};

  // Reset synchronizer: assertion is immediate, release waits two edges.
  logic [1:0] rst_q;
  logic       rst_int;

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) rst_q <= 2'b11;
    else     rst_q <= {rst_q[0], 1'b0};
  end

  assign rst_int = rst_q[1];

  bcd2bin_state_t   state, state_nx;
  logic [BCD_W-1:0] bcd_r, bcd_nx;
  // The magnitude path is as wide as the BCD field so that every bit shifted
  // out of bcd_r over the 4*DIGITS shifts is retained; the value itself
  // never exceeds 10**DIGITS-1, so the top bits stay zero.
  logic [BCD_W-1:0] mag_r, mag_nx;
  logic             neg_r, neg_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] numero_r, numero_nx;
  logic             error_r, error_nx;
  logic             ovf_r, ovf_nx;

  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_fix;
  logic [WIDTH-1:0] mag_w;
  logic             bcd_ok;

  assign bcd_shift = {1'b0, bcd_r[BCD_W-1:1]};
  assign mag_w     = WIDTH'(mag_r);

  for (genvar d = 0; d < DIGITS; d++) begin : g_fix
    module_bcd_nibble_fix u_fix (
      .nib_in  (bcd_shift[4*d +: 4]),
      .nib_out (bcd_fix[4*d +: 4])
    );
  end

  always_comb begin
    bcd_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(bus.bcd_in[4*i +: 4])) bcd_ok = 1'b0;
    end
  end

  always_ff @(posedge clk_div or posedge rst_int) begin
    if (rst_int) begin
      state    <= IDLE;
      bcd_r    <= '0;
      mag_r    <= '0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      numero_r <= '0;
      error_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      bcd_r    <= bcd_nx;
      mag_r    <= mag_nx;
      neg_r    <= neg_nx;
      cnt      <= cnt_nx;
      numero_r <= numero_nx;
      error_r  <= error_nx;
      ovf_r    <= ovf_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    bcd_nx    = bcd_r;
    mag_nx    = mag_r;
    neg_nx    = neg_r;
    cnt_nx    = cnt;
    numero_nx = numero_r;
    error_nx  = error_r;
    ovf_nx    = ovf_r;

    case (state)
      IDLE: begin
        if (bus.valid_in) begin
          bcd_nx = bus.bcd_in;
          neg_nx = bus.neg_in;
          mag_nx = '0;
          cnt_nx = '0;
          if (!bcd_ok) begin
            state_nx  = DONE;
            error_nx  = 1'b1;
            ovf_nx    = 1'b0;
            numero_nx = '0;
          end else begin
            state_nx = CONV;
          end
        end
      end

      CONV: begin
        bcd_nx = bcd_fix;
        mag_nx = {bcd_r[0], mag_r[BCD_W-1:1]};
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) state_nx = SIGN;
      end

      SIGN: begin
        error_nx = 1'b0;
        state_nx = DONE;
        if (!neg_r) begin
          if (32'(mag_r) > POS_LIM) begin
            numero_nx = POS_SAT;
            ovf_nx    = 1'b1;
          end else begin
            numero_nx = mag_w;
            ovf_nx    = 1'b0;
          end
        end else begin
          if (32'(mag_r) > NEG_LIM) begin
            numero_nx = NEG_SAT;
            ovf_nx    = 1'b1;
          end else begin
            // -0 is still 0, so no special case for a negative zero.
            numero_nx = -mag_w;
            ovf_nx    = 1'b0;
          end
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.numero_out = numero_r;
  assign bus.error      = error_r;
  assign bus.ovf        = ovf_r;
  assign bus.listo      = (state == DONE);
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_module_bcd_to_bin.sv
// ----------------------------------------------------------------------------
// tb_module_bcd_to_bin
// Directed-vector bench for module_bcd_to_bin (DIGITS=3, WIDTH=8).
// ----------------------------------------------------------------------------
module tb_module_bcd_to_bin;

  logic clk_div = 1'b0;
  logic rst     = 1'b0;

  always #5 clk_div = ~clk_div;

  module_bcd_to_bin_if #(.DIGITS(3), .WIDTH(8)) bus ();

  module_bcd_to_bin #(.DIGITS(3), .WIDTH(8)) dut (
    .clk_div (clk_div),
    .rst     (rst),
    .bus     (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        neg;
    logic [7:0]  num;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge with the DUT idle; issues a request and
  // follows it to the listo pulse.
  task automatic run_req(input string tag, input vec_t v);
    int n;
    int lat_exp;
    lat_exp = v.err ? 0 : 13;
    chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    bus.valid_in = 1'b1;
    bus.bcd_in   = v.bcd;
    bus.neg_in   = v.neg;
    @(posedge clk_div);
    #1;
    bus.valid_in = 1'b0;
    n = 0;
    while (!bus.listo && n < 40) begin
      @(posedge clk_div);
      #1;
      n++;
    end
    chk({tag, "_listo"},  32'(bus.listo), 32'd1);
    chk({tag, "_lat"},    32'(n), 32'(lat_exp));
    chk({tag, "_numero"}, 32'(bus.numero_out), 32'(v.num));
    chk({tag, "_ovf"},    32'(bus.ovf), 32'(v.ovf));
    chk({tag, "_error"},  32'(bus.error), 32'(v.err));
    @(posedge clk_div);
    #1;
    chk({tag, "_pulse"},  32'(bus.listo), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first;
    logic [7:0] num_seen;
    logic [7:0] num_before;

    vecs[0]  = '{12'h127, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1]  = '{12'h128, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[2]  = '{12'h045, 1'b1, 8'hD3, 1'b0, 1'b0};
    vecs[3]  = '{12'h200, 1'b0, 8'h7F, 1'b1, 1'b0};
    vecs[4]  = '{12'h999, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[5]  = '{12'h1A5, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{12'h005, 1'b0, 8'h05, 1'b0, 1'b0};
    vecs[7]  = '{12'h000, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{12'h099, 1'b0, 8'h63, 1'b0, 1'b0};
    vecs[9]  = '{12'h128, 1'b0, 8'h7F, 1'b1, 1'b0};
    vecs[10] = '{12'h127, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[11] = '{12'hF00, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[12] = '{12'h129, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[13] = '{12'h064, 1'b0, 8'h40, 1'b0, 1'b0};

    bus.valid_in = 1'b0;
    bus.neg_in   = 1'b0;
    bus.bcd_in   = '0;

    #1 rst = 1'b1;
    #10;
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_listo",  32'(bus.listo), 32'd0);
    chk("rst_numero", 32'(bus.numero_out), 32'd0);
    chk("rst_error",  32'(bus.error), 32'd0);
    chk("rst_ovf",    32'(bus.ovf), 32'd0);
    @(negedge clk_div);
    rst = 1'b0;
    repeat (3) @(posedge clk_div);
    #1;

    // Back-to-back: each request starts in the IDLE cycle right after DONE.
    for (int i = 0; i < 14; i++) begin
      run_req($sformatf("v%0d", i), vecs[i]);
    end

    // Second request while busy must be dropped.
    bus.valid_in = 1'b1;
    bus.bcd_in   = 12'h050;
    bus.neg_in   = 1'b0;
    @(posedge clk_div);
    #1;
    bus.valid_in = 1'b0;
    repeat (3) @(posedge clk_div);
    #1;
    bus.valid_in = 1'b1;
    bus.bcd_in   = 12'h099;
    bus.neg_in   = 1'b1;
    @(posedge clk_div);
    #1;
    bus.valid_in = 1'b0;
    pulses   = 0;
    first    = -1;
    num_seen = '0;
    for (int e = 4; e <= 40; e++) begin
      if (bus.listo) begin
        pulses++;
        if (first < 0) begin
          first    = e;
          num_seen = bus.numero_out;
        end
      end
      @(posedge clk_div);
      #1;
    end
    chk("busy_pulses", 32'(pulses), 32'd1);
    chk("busy_lat",    32'(first), 32'd13);
    chk("busy_numero", 32'(num_seen), 32'h32);
    chk("busy_final",  32'(bus.numero_out), 32'h32);

    // Reset in the middle of a conversion.
    num_before = bus.numero_out;
    chk("mid_pre_numero", 32'(num_before), 32'h32);
    bus.valid_in = 1'b1;
    bus.bcd_in   = 12'h127;
    bus.neg_in   = 1'b1;
    @(posedge clk_div);
    #1;
    bus.valid_in = 1'b0;
    repeat (5) @(posedge clk_div);
    #1;
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    @(posedge clk_div);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_busy",   32'(bus.busy), 32'd0);
    chk("mid_numero", 32'(bus.numero_out), 32'd0);
    chk("mid_listo",  32'(bus.listo), 32'd0);
    chk("mid_error",  32'(bus.error), 32'd0);
    chk("mid_ovf",    32'(bus.ovf), 32'd0);
    @(negedge clk_div);
    rst = 1'b0;
    pulses = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk_div);
      #1;
      if (bus.listo) pulses++;
    end
    chk("mid_no_listo", 32'(pulses), 32'd0);

    run_req("post_rst", vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
